// File: rtl/text_grid_pkg.sv
// Shared constants for the character-grid text buffer: control codes,
// the empty-cell value and the controller state encoding.
package text_grid_pkg;

  localparam int unsigned CODE_CR    = 32'h0D;
  localparam int unsigned CODE_BS    = 32'h7F;
  localparam int unsigned CODE_FF    = 32'h0C;
  localparam int unsigned EMPTY_CELL = 32'h00;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WIPE_ROW = 2'd1,
    ST_WIPE_ALL = 2'd2,
    ST_BS_SCAN  = 2'd3
  } state_e;

endpackage

// File: rtl/text_grid_buffer_grid_ram.sv
// Cell storage: one synchronous write port, a registered display read port
// and a combinational scan read port used by the backspace search.
module grid_ram #(
  parameter int DEPTH  = 64,
  parameter int DATA_W = 24,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o,
  input  logic [ADDR_W-1:0] saddr_i,
  output logic [DATA_W-1:0] sdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Contents are not reset; the controller wipes the array after reset.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;
  assign sdata_o = mem_q[saddr_i];

endmodule

// File: rtl/text_grid_buffer.sv
// Character-grid text buffer: cursor tracking, CR/BS/FF handling and
// ring-pointer scrolling over a RAM-mappable cell array.
module text_grid_buffer
  import text_grid_pkg::*;
#(
  parameter int ROWS   = 4,
  parameter int COLS   = 16,
  parameter int DATA_W = 24,
  localparam int ROW_W = $clog2(ROWS),
  localparam int COL_W = $clog2(COLS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [ROW_W-1:0]  rd_row,
  input  logic [COL_W-1:0]  rd_col,
  output logic [DATA_W-1:0] rd_data,
  output logic [ROW_W-1:0]  cur_row,
  output logic [COL_W-1:0]  cur_col,
  output logic              busy
);

  localparam int CNT_W = ROW_W + COL_W;
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = '1;
  localparam logic [DATA_W-1:0] EMPTY   = DATA_W'(EMPTY_CELL);

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [ROW_W-1:0]  top_q;
  logic [ROW_W-1:0]  cur_row_q;
  logic [COL_W-1:0]  cur_col_q;

  logic              accept;
  logic              is_cr;
  logic              is_bs;
  logic              is_ff;
  logic [COL_W-1:0]  cnt_col;
  logic [ROW_W-1:0]  cur_phys_row;
  logic [ROW_W-1:0]  bottom_phys_row;
  logic [ROW_W-1:0]  rd_phys_row;
  logic              wr_en;
  logic [CNT_W-1:0]  wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] scan_data;

  assign accept          = in_valid && (state_q == ST_IDLE);
  assign is_cr           = (in_data == DATA_W'(CODE_CR));
  assign is_bs           = (in_data == DATA_W'(CODE_BS));
  assign is_ff           = (in_data == DATA_W'(CODE_FF));
  assign cnt_col         = cnt_q[COL_W-1:0];
  assign cur_phys_row    = top_q + cur_row_q;
  assign bottom_phys_row = top_q + LAST_ROW;
  assign rd_phys_row     = top_q + rd_row;

  always_comb begin
    wr_en   = 1'b0;
    wr_addr = {cur_phys_row, cur_col_q};
    wr_data = EMPTY;
    unique case (state_q)
      ST_IDLE: begin
        if (accept && !is_cr && !is_ff) begin
          if (is_bs) begin
            wr_en   = (cur_col_q != '0);
            wr_addr = {cur_phys_row, cur_col_q - COL_W'(1)};
          end else begin
            wr_en   = 1'b1;
            wr_data = in_data;
          end
        end
      end
      ST_WIPE_ROW: begin
        wr_en   = 1'b1;
        wr_addr = {bottom_phys_row, cnt_col};
      end
      // top is 0 during a full wipe, so the counter is the physical address.
      ST_WIPE_ALL: begin
        wr_en   = 1'b1;
        wr_addr = cnt_q;
      end
      default: begin
        wr_en = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_WIPE_ALL;
      cnt_q     <= '0;
      top_q     <= '0;
      cur_row_q <= '0;
      cur_col_q <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (accept) begin
            if (is_ff) begin
              top_q     <= '0;
              cur_row_q <= '0;
              cur_col_q <= '0;
              cnt_q     <= '0;
              state_q   <= ST_WIPE_ALL;
            end else if (is_bs) begin
              if (cur_col_q != '0) begin
                cur_col_q <= cur_col_q - COL_W'(1);
              end else if (cur_row_q != '0) begin
                cur_row_q <= cur_row_q - ROW_W'(1);
                cnt_q     <= {{ROW_W{1'b0}}, LAST_COL};
                state_q   <= ST_BS_SCAN;
              end
            end else if (is_cr || cur_col_q == LAST_COL) begin
              cur_col_q <= '0;
              if (cur_row_q == LAST_ROW) begin
                top_q   <= top_q + ROW_W'(1);
                cnt_q   <= '0;
                state_q <= ST_WIPE_ROW;
              end else begin
                cur_row_q <= cur_row_q + ROW_W'(1);
              end
            end else begin
              cur_col_q <= cur_col_q + COL_W'(1);
            end
          end
        end
        ST_WIPE_ROW: begin
          if (cnt_col == LAST_COL) begin
            cnt_q   <= '0;
            state_q <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_WIPE_ALL: begin
          if (cnt_q == LAST_CNT) begin
            cnt_q   <= '0;
            state_q <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_BS_SCAN: begin
          // Land just after the last character, clamped to the final column.
          if (scan_data != EMPTY) begin
            cur_col_q <= (cnt_col == LAST_COL) ? LAST_COL : cnt_col + COL_W'(1);
            cnt_q     <= '0;
            state_q   <= ST_IDLE;
          end else if (cnt_col == '0) begin
            cur_col_q <= '0;
            state_q   <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        default: begin
          cnt_q   <= '0;
          state_q <= ST_WIPE_ALL;
        end
      endcase
    end
  end

  grid_ram #(
    .DEPTH  (ROWS * COLS),
    .DATA_W (DATA_W)
  ) u_grid_ram (
    .clk     (clk),
    .reset   (reset),
    .we_i    (wr_en),
    .waddr_i (wr_addr),
    .wdata_i (wr_data),
    .raddr_i ({rd_phys_row, rd_col}),
    .rdata_o (rd_data),
    .saddr_i ({cur_phys_row, cnt_col}),
    .sdata_o (scan_data)
  );

  assign in_ready = (state_q == ST_IDLE);
  assign busy     = (state_q != ST_IDLE);
  assign cur_row  = cur_row_q;
  assign cur_col  = cur_col_q;

endmodule

// File: tb/tb_text_grid_buffer.sv
// Self-checking bench for text_grid_buffer: logical-grid reference model,
// read scoreboard, table of control-code vectors and reset corner cases.
module tb_text_grid_buffer;

  localparam int ROWS = 4;
  localparam int COLS = 16;
  localparam int DW   = 24;
  localparam logic [DW-1:0] K_CR = 24'h0D;
  localparam logic [DW-1:0] K_BS = 24'h7F;
  localparam logic [DW-1:0] K_FF = 24'h0C;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic [1:0]    rd_row;
  logic [3:0]    rd_col;
  logic [DW-1:0] rd_data;
  logic [1:0]    cur_row;
  logic [3:0]    cur_col;
  logic          busy;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] mgrid [ROWS][COLS];
  int            mrow;
  int            mcol;
  logic [DW-1:0] sb_q [$];

  typedef struct {
    logic [DW-1:0] code;
    int            row;
    int            col;
    int            busy_cycles;
  } vec_t;
  vec_t vt [16];

  text_grid_buffer #(.ROWS(ROWS), .COLS(COLS), .DATA_W(DW)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .rd_row   (rd_row),
    .rd_col   (rd_col),
    .rd_data  (rd_data),
    .cur_row  (cur_row),
    .cur_col  (cur_col),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        mgrid[r][c] = '0;
    mrow = 0;
    mcol = 0;
  endtask

  task automatic model_scroll();
    for (int r = 0; r < ROWS - 1; r++)
      for (int c = 0; c < COLS; c++)
        mgrid[r][c] = mgrid[r+1][c];
    for (int c = 0; c < COLS; c++)
      mgrid[ROWS-1][c] = '0;
  endtask

  task automatic model_newline();
    mcol = 0;
    if (mrow < ROWS - 1) mrow++;
    else model_scroll();
  endtask

  task automatic model_apply(input logic [DW-1:0] code);
    bit found;
    if (code == K_FF) begin
      model_clear();
    end else if (code == K_CR) begin
      model_newline();
    end else if (code == K_BS) begin
      if (mcol > 0) begin
        mcol--;
        mgrid[mrow][mcol] = '0;
      end else if (mrow > 0) begin
        mrow--;
        found = 0;
        mcol  = 0;
        for (int c = COLS - 1; c >= 0; c--) begin
          if (!found && mgrid[mrow][c] != '0) begin
            found = 1;
            mcol  = (c + 1 > COLS - 1) ? COLS - 1 : c + 1;
          end
        end
      end
    end else begin
      mgrid[mrow][mcol] = code;
      if (mcol < COLS - 1) mcol++;
      else model_newline();
    end
  endtask

  // Drive one address per cycle, push the model value, compare one cycle later.
  task automatic check_screen(input string tag);
    logic [DW-1:0] exp;
    int            idx;
    idx = 0;
    for (int i = 0; i <= ROWS * COLS; i++) begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        exp = sb_q.pop_front();
        chk($sformatf("%s_cell_r%0d_c%0d", tag, idx / COLS, idx % COLS), 32'(rd_data), 32'(exp));
        idx++;
      end
      if (i < ROWS * COLS) begin
        rd_row = 2'(i / COLS);
        rd_col = 4'(i % COLS);
        sb_q.push_back(mgrid[i / COLS][i % COLS]);
      end
    end
  endtask

  task automatic chk_cursor(input string tag);
    chk({tag, "_cur_row"}, 32'(cur_row), 32'(mrow));
    chk({tag, "_cur_col"}, 32'(cur_col), 32'(mcol));
  endtask

  task automatic send(input logic [DW-1:0] code, output int waited);
    waited = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = code;
    while (!in_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) chk("send_accept", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    model_apply(code);
    $display("tx code=%02h cursor=(%0d,%0d) waited=%0d", code, cur_row, cur_col, waited);
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic ready_delay_after_release(input string tag);
    int n;
    @(negedge clk);
    reset = 1'b0;
    n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({tag, "_wipe_cycles"}, 32'(n), 32'd64);
    model_clear();
  endtask

  task automatic pulse_reset(input string tag);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk({tag, "_busy_in_reset"}, 32'(busy), 32'd1);
    chk({tag, "_ready_in_reset"}, 32'(in_ready), 32'd0);
    ready_delay_after_release(tag);
  endtask

  initial begin
    int w;
    int n;
    int accepts;

    vt[0]  = '{24'h41, 0, 1, 0};
    vt[1]  = '{24'h42, 0, 2, 0};
    vt[2]  = '{24'h43, 0, 3, 0};
    vt[3]  = '{K_CR,   1, 0, 0};
    vt[4]  = '{K_BS,   0, 3, 14};
    vt[5]  = '{K_BS,   0, 2, 0};
    vt[6]  = '{K_BS,   0, 1, 0};
    vt[7]  = '{K_BS,   0, 0, 0};
    vt[8]  = '{K_BS,   0, 0, 0};
    vt[9]  = '{K_CR,   1, 0, 0};
    vt[10] = '{K_CR,   2, 0, 0};
    vt[11] = '{K_BS,   1, 0, 16};
    vt[12] = '{24'h44, 1, 1, 0};
    vt[13] = '{K_CR,   2, 0, 0};
    vt[14] = '{K_BS,   1, 1, 16};
    vt[15] = '{K_BS,   1, 0, 0};

    in_valid = 1'b0;
    in_data  = '0;
    rd_row   = '0;
    rd_col   = '0;
    reset    = 1'b1;
    model_clear();

    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", 32'(busy), 32'd1);
    chk("reset_in_ready", 32'(in_ready), 32'd0);
    chk("reset_rd_data", 32'(rd_data), 32'd0);
    chk("reset_cur_row", 32'(cur_row), 32'd0);
    chk("reset_cur_col", 32'(cur_col), 32'd0);
    ready_delay_after_release("reset");
    check_screen("reset");

    // Back-to-back printable stream fills row 0 in 16 cycles.
    accepts = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 24'h41 + 24'(i);
      if (in_ready) accepts++;
      model_apply(in_data);
    end
    @(negedge clk);
    in_valid = 1'b0;
    chk("stream_accepts", 32'(accepts), 32'd16);
    chk("stream_cur_row", 32'(cur_row), 32'd1);
    chk("stream_cur_col", 32'(cur_col), 32'd0);
    check_screen("stream");

    for (int i = 0; i < 47; i++) send(24'h61 + 24'(i % 20), w);
    chk("fill_cur_row", 32'(cur_row), 32'd3);
    chk("fill_cur_col", 32'(cur_col), 32'd15);
    send(24'h5A, w);
    wait_idle(n);
    chk("scroll_busy_cycles", 32'(n), 32'd16);
    chk("scroll_cur_row", 32'(cur_row), 32'd3);
    chk("scroll_cur_col", 32'(cur_col), 32'd0);
    check_screen("scroll");

    // A code offered during the clear must stall, not drop.
    send(K_FF, w);
    send(24'h58, w);
    chk("ff_stall_cycles", 32'(w), 32'd64);
    chk_cursor("ff_then_x");
    check_screen("ff_then_x");
    send(K_BS, w);
    chk_cursor("ff_clean");

    for (int i = 0; i < 16; i++) begin
      send(vt[i].code, w);
      chk($sformatf("vec%0d_accept_wait", i), 32'(w), 32'd0);
      wait_idle(n);
      chk($sformatf("vec%0d_busy_cycles", i), 32'(n), 32'(vt[i].busy_cycles));
      chk($sformatf("vec%0d_cur_row", i), 32'(cur_row), 32'(vt[i].row));
      chk($sformatf("vec%0d_cur_col", i), 32'(cur_col), 32'(vt[i].col));
      chk_cursor($sformatf("vec%0d_model", i));
    end
    check_screen("table");

    // Reset during WIPE_ALL restarts the full wipe.
    send(24'h66, w);
    send(K_FF, w);
    repeat (10) @(posedge clk);
    pulse_reset("ff_reset");
    chk_cursor("ff_reset");
    check_screen("ff_reset");

    // Reset during WIPE_ROW must also return top to 0.
    send(24'h77, w);
    send(K_CR, w);
    send(K_CR, w);
    send(K_CR, w);
    send(K_CR, w);
    repeat (5) @(posedge clk);
    pulse_reset("scroll_reset");
    send(24'h41, w);
    chk_cursor("scroll_reset");
    check_screen("scroll_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/text_grid_buffer.md
# text_grid_buffer

Parametrised character-grid text buffer: stores keyboard/UART codes in a ROWS x COLS grid with cursor tracking, line feed, backspace with previous-row scan, clear-screen and ring-pointer scrolling. Sits between the input decoder (valid/ready source) and the display renderer, which reads cells by logical row/column. It replaces whole-array row shifting with a top-row pointer and a single-write-port sequential wipe, so the array can map to RAM.

## Interface
- ROWS, 4, grid rows (power of two, >= 2)
- COLS, 16, grid columns (power of two, >= 2)
- DATA_W, 24, cell width; control codes match on full zero-extended value
- ROW_W, $clog2(ROWS), row index width (derived)
- COL_W, $clog2(COLS), column index width (derived)
- clk  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- in_valid  in  1  producer has a code
- in_ready  out  1  block accepts a code this cycle
- in_data  in  DATA_W  code; accepted when in_valid && in_ready
- rd_row  in  ROW_W  logical display row (0 = top of screen)
- rd_col  in  COL_W  display column
- rd_data  out  DATA_W  registered cell contents
- cur_row  out  ROW_W  cursor logical row
- cur_col  out  COL_W  cursor column
- busy  out  1  high in any state other than IDLE

## Operation
- Codes: CR = 'h0D, BS = 'h7F, FF = 'h0C (clear screen); any other value is printable. Empty cell = 0.
- Physical row = (top + logical row) mod ROWS; top is internal, ROW_W bits, wraps naturally.
- States: IDLE, WIPE_ROW, WIPE_ALL, BS_SCAN. in_ready = (state == IDLE).
- Printable in IDLE: write cell (cur_row, cur_col). If cur_col < COLS-1: cur_col+1. Else cur_col=0, and if cur_row < ROWS-1: cur_row+1, else scroll.
- CR: cur_col=0; cur_row < ROWS-1 -> cur_row+1, else scroll.
- Scroll: top <= top+1, cur_row stays ROWS-1, go WIPE_ROW; wipe counter clears new bottom row columns 0..COLS-1, one per cycle, then IDLE.
- BS: cur_col > 0 -> cur_col-1 and clear that cell, stay IDLE. cur_col == 0 && cur_row > 0 -> cur_row-1, go BS_SCAN: test columns COLS-1 down to 0 of the new row, one per cycle; first nonzero at c sets cur_col = min(c+1, COLS-1), then IDLE; none found -> cur_col=0. BS at (0,0): accepted, no effect.
- FF: top=0, cursor (0,0), go WIPE_ALL: clear all ROWS*COLS cells, one per cycle, then IDLE.
- Read port independent of state; always valid, including during wipes.

## Timing
- Reset: state=WIPE_ALL, counter=0, top=0, cursor (0,0), rd_data=0, in_ready=0, busy=1. The array is valid (all zero) ROWS*COLS cycles after reset deasserts.
- Reset mid-wipe/mid-scan restarts WIPE_ALL from counter 0.
- Throughput: one printable/CR-without-scroll/in-row BS per cycle, back to back.
- Busy latency: scroll COLS cycles; FF ROWS*COLS cycles; BS_SCAN 1..COLS cycles (COLS-c for a hit at column c, COLS if none).
- Write at edge N is visible in rd_data at edge N+1 for a read addressed during cycle N+1 (rd_data registered, 1-cycle read latency). A same-cycle read/write returns the old value.
- in_valid while busy: no acceptance; producer holds in_data (standard valid/ready, no drop).
- cur_row/cur_col update at the acceptance edge, including the edge entering BS_SCAN (row) and the exit edge (col).

## Structure
- Package text_grid_pkg: code constants (CR, BS, FF), state enum, empty-cell constant.
- Sub-module grid_ram: ROWS*COLS x DATA_W, one sync write port, one registered read port (display), one combinational read port (scan); address = {physical row, col}.
- The top-level holds the FSM, cursor, top pointer and wipe/scan counter (shared, COL_W+ROW_W bits).

## Test plan
- Reset, then read all cells -> in_ready low for 64 cycles (defaults), then all zero, cursor (0,0).
- Stream 'h41..'h50 back to back -> 16 accepts in 16 cycles, row 0 = 'h41..'h50, cursor (1,0).
- Fill to (3,15) and send 'h5A -> busy 16 cycles; logical row 3 all zero, former row 1 now at row 0, cursor (3,0).
- Write 'h41,'h42,'h43 at row 0, CR, BS -> BS_SCAN finds c=2, cursor (0,3); another BS clears (0,2), cursor (0,2).
- BS at (0,0) -> accepted in 1 cycle, no cell or cursor change; CR on empty row 1, BS -> scan 16 cycles, cursor (1,0).
- Send FF mid-screen, then raise reset during WIPE_ALL -> wipe restarts, top=0, in_ready low until 64 cycles after reset release.
